uart_frame_loader: RTL and testbench

Sequences the UART byte receiver into the face-detection image memory. Buffers received bytes in a small FIFO and waits for a sync byte to find the start of a frame. It then writes exactly IMG_W*IMG_H pixel bytes into the image RAM through a request/grant write port shared with the detector. It also drives the RTS flow-control line (fpga_can_receive) toward the laptop, and hands the finished frame to the detector with a done/ack handshake.

---
 rtl/uart_frame_loader.sv | 111 +++++++++++
 tb/tb_uart_frame_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: buffers UART bytes in a FIFO, locks onto a sync byte and writes
// one IMG_W*IMG_H frame into the shared image RAM, driving RTS and a done/ack handshake.
module uart_frame_loader #(
   parameter int         IMG_W          = 160,
   parameter int         IMG_H          = 120,
   parameter int         FIFO_DEPTH     = 16,
   parameter int         RTS_MARGIN     = 4,
   parameter int         TIMEOUT_CYCLES = 2_000_000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         AW             = $clog2(IMG_W*IMG_H)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          uart_data_rdy_i,
   input  logic [7:0]    uart_data_i,
   output logic          mem_req_o,
   input  logic          mem_gnt_i,
   output logic [AW-1:0] mem_addr_o,
   output logic [7:0]    mem_wdata_o,
   output logic          fpga_can_receive_o,
   output logic          frame_done_o,
   input  logic          frame_ack_i,
   output logic          frame_err_o,
   output logic          busy_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [PW:0]   FULL     = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   RTS_LIM  = (PW+1)'(FIFO_DEPTH - RTS_MARGIN);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] PIX_LAST = AW'(IMG_W*IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [AW-1:0] pix_q, pix_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d, rts_q;
   logic          empty, pop, push, ovf;

   always_comb begin
      empty       = cnt_q == '0;
      mem_req_o   = state_q == RECV && !empty;
      mem_wdata_o = mem_req_o ? fifo_q[rd_q] : '0;
      pop         = (state_q == IDLE && !empty) || (mem_req_o && mem_gnt_i);
      push        = uart_data_rdy_i && (cnt_q != FULL || pop);
      ovf         = uart_data_rdy_i && !push;
      state_d     = state_q;
      pix_d       = pix_q;
      err_d       = 1'b0;
      wr_d        = push ? wr_q + 1'b1 : wr_q;
      rd_d        = pop ? rd_q + 1'b1 : rd_q;
      cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      tmo_d       = push ? '0 : ((tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1);
      case (state_q)
         IDLE: if (pop && fifo_q[rd_q] == SYNC_BYTE) begin
            state_d = RECV;
            pix_d   = '0;
            tmo_d   = '0;
         end
         RECV: if (ovf || (empty && !push && tmo_q == TMO_LAST)) begin
            state_d = IDLE;
            pix_d   = '0;
            err_d   = 1'b1;
            // an overflow leaves the FIFO inconsistent with the frame, so drop it all
            if (ovf) begin
               rd_d  = wr_q;
               cnt_d = '0;
            end
         end else if (pop) begin
            pix_d   = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
            state_d = (pix_q == PIX_LAST) ? DONE : RECV;
         end
         DONE: if (frame_ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         pix_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         rts_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         rts_q   <= state_d != DONE && cnt_d < RTS_LIM;
      end
   end

   always_ff @(posedge clock) if (push) fifo_q[wr_q] <= uart_data_i;

   assign mem_addr_o         = pix_q;
   assign fpga_can_receive_o = rts_q;
   assign frame_done_o       = state_q == DONE;
   assign frame_err_o        = err_q;
   assign busy_o             = state_q == RECV;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: vector table of whole frames, hand-written corner sequences and a
// randomized multi-frame run checked against a byte-stream frame parser.
module tb_uart_frame_loader;
   localparam int NPIX = 8;
   localparam int NF   = 20;

   typedef struct {
      string      name;
      int         n;
      logic [7:0] b  [12];
      logic [7:0] px [8];
   } vec_t;

   logic       clock = 1'b0, reset = 1'b1;
   logic       uart_data_rdy = 1'b0;
   logic [7:0] uart_data = '0;
   logic       mem_req, mem_gnt, fpga_can_receive, frame_done, frame_err, busy, frame_ack;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   int         gnt_mode = 0;
   logic       gnt_rnd = 1'b0, ack_man = 1'b0, ack_rnd = 1'b0, rnd_on = 1'b0;
   int         n_cmp = 0, n_bad = 0, err_cnt = 0, done_rises = 0, ack_wait = 0;
   int         cap_a [$];
   logic [7:0] cap_d [$];
   logic       stall_prev = 1'b0, done_prev = 1'b0;
   logic [2:0] a_prev = '0;
   logic [7:0] d_prev = '0;

   assign mem_gnt   = (gnt_mode == 2) ? gnt_rnd : (gnt_mode == 1);
   assign frame_ack = ack_man | ack_rnd;

   uart_frame_loader #(
      .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(16), .RTS_MARGIN(4),
      .TIMEOUT_CYCLES(50), .SYNC_BYTE(8'hA5)
   ) dut (
      .clock(clock), .reset(reset),
      .uart_data_rdy_i(uart_data_rdy), .uart_data_i(uart_data),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .fpga_can_receive_o(fpga_can_receive), .frame_done_o(frame_done), .frame_ack_i(frame_ack),
      .frame_err_o(frame_err), .busy_o(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(logic [7:0] b);
      uart_data     = b;
      uart_data_rdy = 1'b1;
      tick();
      uart_data_rdy = 1'b0;
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_req"},   32'(mem_req), 0);
      chk({nm, "_addr"},  32'(mem_addr), 0);
      chk({nm, "_wdata"}, 32'(mem_wdata), 0);
      chk({nm, "_done"},  32'(frame_done), 0);
      chk({nm, "_err"},   32'(frame_err), 0);
      chk({nm, "_busy"},  32'(busy), 0);
      chk({nm, "_rts"},   32'(fpga_can_receive), 0);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      uart_data_rdy = 1'b0;
      ack_man       = 1'b0;
      gnt_mode      = 0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      cap_a.delete();
      cap_d.delete();
   endtask

   task automatic wait_done(string nm, int max);
      int k = 0;
      while (!frame_done && k < max) begin
         tick();
         k++;
      end
      chk(nm, 32'(frame_done), 1);
   endtask

   task automatic check_writes(string nm, logic [7:0] px [8], int n);
      chk({nm, "_nwr"}, cap_a.size(), n);
      for (int i = 0; i < n; i++)
         if (i < cap_a.size()) begin
            chk({nm, "_addr"}, cap_a[i], i);
            chk({nm, "_data"}, 32'(cap_d[i]), 32'(px[i]));
         end
      cap_a.delete();
      cap_d.delete();
   endtask

   task automatic ack();
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
   endtask

   // Write capture, hold-while-stalled check and event counters, sampled mid-cycle
   always @(negedge clock) begin
      if (!reset && mem_req && mem_gnt) begin
         cap_a.push_back(int'(mem_addr));
         cap_d.push_back(mem_wdata);
      end
      if (stall_prev && mem_req) begin
         chk("hold_addr", 32'(mem_addr), 32'(a_prev));
         chk("hold_data", 32'(mem_wdata), 32'(d_prev));
      end
      stall_prev = !reset && mem_req && !mem_gnt;
      a_prev     = mem_addr;
      d_prev     = mem_wdata;
      if (frame_err) err_cnt++;
      if (frame_done && !done_prev) done_rises++;
      done_prev = frame_done;
   end

   initial forever begin
      @(posedge clock);
      #1;
      gnt_rnd = $urandom_range(0, 3) != 0;
      ack_rnd = 1'b0;
      if (rnd_on && frame_done) begin
         if (ack_wait == 0) begin
            ack_rnd  = 1'b1;
            ack_wait = $urandom_range(0, 5);
         end else ack_wait--;
      end
   end

   initial begin
      vec_t       v [3];
      logic [7:0] px [8];
      logic [7:0] stream [$];
      int         ea [$];
      logic [7:0] ed [$];
      logic [7:0] g;
      int         k, e0, d0;

      v[0].name = "nominal";
      v[0].n    = 9;
      v[0].b    = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h00, 8'h00, 8'h00};
      v[0].px   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
      v[1].name = "sync_search";
      v[1].n    = 11;
      v[1].b    = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h21, 8'hA5, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h00};
      v[1].px   = '{8'h20, 8'h21, 8'hA5, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
      v[2].name = "sync_as_pixel";
      v[2].n    = 9;
      v[2].b    = '{8'hA5, 8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h00, 8'h00, 8'h00};
      v[2].px   = '{8'hA5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};

      repeat (3) tick();
      chk_zero("rst");
      reset = 1'b0;
      chk("rts_before_edge", 32'(fpga_can_receive), 0);
      tick();
      chk("rts_after_edge", 32'(fpga_can_receive), 1);

      foreach (v[t]) begin
         do_reset();
         gnt_mode = 1;
         for (int i = 0; i < v[t].n; i++) send(v[t].b[i]);
         wait_done({v[t].name, "_done"}, 40);
         check_writes(v[t].name, v[t].px, NPIX);
         chk({v[t].name, "_busy"}, 32'(busy), 0);
         ack();
         chk({v[t].name, "_ack_done"}, 32'(frame_done), 0);
         chk({v[t].name, "_ack_busy"}, 32'(busy), 0);
      end

      do_reset();
      send(8'hA5);
      for (int i = 0; i < 12; i++) begin
         send(8'(8'h30 + i));
         if (i == 10) chk("stall_rts_11", 32'(fpga_can_receive), 1);
      end
      chk("stall_rts_12", 32'(fpga_can_receive), 0);
      chk("stall_req", 32'(mem_req), 1);
      chk("stall_addr", 32'(mem_addr), 0);
      chk("stall_data", 32'(mem_wdata), 32'h30);
      chk("stall_nwr", cap_a.size(), 0);
      gnt_mode = 1;
      tick();
      chk("stall_rts_resume", 32'(fpga_can_receive), 1);
      wait_done("stall_done", 20);
      px = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
      check_writes("stall", px, NPIX);
      chk("done_rts", 32'(fpga_can_receive), 0);
      send(8'h40);
      send(8'h41);
      chk("done_hold_rts", 32'(fpga_can_receive), 0);
      chk("done_hold_done", 32'(frame_done), 1);
      chk("done_hold_req", 32'(mem_req), 0);
      ack();
      chk("done_ack_done", 32'(frame_done), 0);
      chk("done_ack_rts", 32'(fpga_can_receive), 1);

      do_reset();
      e0 = err_cnt;
      send(8'hA5);
      for (int i = 0; i < 17; i++) send(8'(8'h50 + i));
      chk("ovf_err", 32'(frame_err), 1);
      chk("ovf_busy", 32'(busy), 0);
      tick();
      chk("ovf_err_fall", 32'(frame_err), 0);
      gnt_mode = 1;
      repeat (5) tick();
      chk("ovf_pulses", err_cnt - e0, 1);
      chk("ovf_nwr", cap_a.size(), 0);
      chk("ovf_rts", 32'(fpga_can_receive), 1);

      do_reset();
      gnt_mode = 1;
      e0 = err_cnt;
      send(8'hA5);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      k = 0;
      while (!frame_err && k < 200) begin
         tick();
         k++;
      end
      chk("tmo_delay", k, 50);
      tick();
      chk("tmo_pulses", err_cnt - e0, 1);
      chk("tmo_busy", 32'(busy), 0);
      px = '{8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_writes("tmo_part", px, 3);
      send(8'hA5);
      for (int i = 0; i < NPIX; i++) send(8'(8'h70 + i));
      wait_done("tmo_next_done", 20);
      px = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77};
      check_writes("tmo_next", px, NPIX);
      ack();

      do_reset();
      gnt_mode = 1;
      e0 = err_cnt;
      send(8'hA5);
      send(8'h80);
      send(8'h81);
      send(8'h82);
      tick();
      reset = 1'b1;
      #1;
      chk_zero("midrst");
      repeat (3) tick();
      reset = 1'b0;
      repeat (80) tick();
      chk("midrst_noerr", err_cnt - e0, 0);
      chk("midrst_rts", 32'(fpga_can_receive), 1);
      chk("midrst_busy", 32'(busy), 0);

      // Reference: the frame parser skips anything up to SYNC, then the next 8 bytes are pixels 0..7
      do_reset();
      for (int f = 0; f < NF; f++) begin
         repeat ($urandom_range(0, 3)) begin
            g = 8'($urandom_range(0, 254));
            if (g >= 8'hA5) g++;
            stream.push_back(g);
         end
         stream.push_back(8'hA5);
         for (int i = 0; i < NPIX; i++) begin
            g = 8'($urandom_range(0, 255));
            stream.push_back(g);
            ea.push_back(i);
            ed.push_back(g);
         end
      end
      gnt_mode = 2;
      rnd_on   = 1'b1;
      d0       = done_rises;
      foreach (stream[i]) begin
         repeat ($urandom_range(0, 3)) tick();
         k = 0;
         while (!fpga_can_receive && k < 500) begin
            tick();
            k++;
         end
         if (k == 500) chk("rnd_rts_stuck", 32'(fpga_can_receive), 1);
         send(stream[i]);
      end
      k = 0;
      while ((done_rises - d0 < NF || cap_a.size() < NF*NPIX) && k < 2000) begin
         tick();
         k++;
      end
      repeat (10) tick();
      rnd_on   = 1'b0;
      gnt_mode = 0;
      chk("rnd_frames", done_rises - d0, NF);
      chk("rnd_nwr", cap_a.size(), ea.size());
      foreach (ea[i])
         if (i < cap_a.size()) begin
            chk("rnd_addr", cap_a[i], ea[i]);
            chk("rnd_data", 32'(cap_d[i]), 32'(ed[i]));
         end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
